// File: rtl/tff_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tff_counter
//  Purpose  : Multi-mode register built from T flip-flops. Operating modes:
//             HOLD, per-bit TOGGLE, modulo UP count and modulo DOWN count.
//             It also has a synchronous load, a one-cycle terminal-count
//             pulse and a sticky wrap flag.
//  Ports    : clk      - clock; all state updates on the rising edge
//             rst      - asynchronous active-high reset
//             en       - step enable for HOLD/TOGGLE/UP/DOWN
//             mode     - 00 HOLD, 01 TOGGLE, 10 UP, 11 DOWN
//             t        - per-bit toggle mask (TOGGLE only)
//             ld       - synchronous load strobe (beats en and mode)
//             d        - load value
//             clr_ovf  - synchronous clear of ovf (a same-edge wrap wins)
//             q        - registered state
//             tc       - registered terminal-count pulse, one cycle per wrap
//             ovf      - registered sticky wrap flag
//  Revision : 1.0 - initial release
// ============================================================================
module tff_counter #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Elaboration-time parameter range checks.
    if (WIDTH < 2 || WIDTH > 32) begin : g_chk_width
        $error("tff_counter: WIDTH must be in 2..32");
    end
    if (MODULUS == 64'd1 || MODULUS > (64'd1 << WIDTH)) begin : g_chk_modulus
        $error("tff_counter: MODULUS must be 0 or in 2..2^WIDTH");
    end

    localparam logic [1:0] c_mode_hold   = 2'b00;
    localparam logic [1:0] c_mode_toggle = 2'b01;
    localparam logic [1:0] c_mode_up     = 2'b10;
    localparam logic [1:0] c_mode_down   = 2'b11;

    // Largest count value. It is the UP wrap threshold and the DOWN reload
    // value. With MODULUS=0 it is all ones, so the UP compare reduces to the
    // natural binary rollover.
    localparam logic [WIDTH-1:0] c_top =
        (MODULUS == 64'd0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_up_t;    // toggle enables of the increment chain
    logic [WIDTH-1:0] w_dn_t;    // toggle enables of the decrement chain
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap;

    // Synchronous T-flip-flop ripple chains. For an increment, bit i toggles
    // when all lower bits are 1. For a decrement, bit i toggles when all lower
    // bits are 0.
    assign w_up_t[0] = 1'b1;
    assign w_dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tchain
        assign w_up_t[i] = w_up_t[i-1] &  r_q[i-1];
        assign w_dn_t[i] = w_dn_t[i-1] & ~r_q[i-1];
    end

    always_comb begin
        w_q_next = r_q;
        w_wrap   = 1'b0;
        if (ld) begin
            w_q_next = d;
        end else if (en) begin
            case (mode)
                c_mode_hold: begin
                    w_q_next = r_q;
                end
                c_mode_toggle: begin
                    w_q_next = r_q ^ t;
                end
                c_mode_up: begin
                    // ">=" and not "==": a value loaded above the modulus
                    // wraps at the next step and does not run on.
                    if (r_q >= c_top) begin
                        w_q_next = '0;
                        w_wrap   = 1'b1;
                    end else begin
                        w_q_next = r_q ^ w_up_t;
                    end
                end
                c_mode_down: begin
                    // Values above the modulus count down normally. Only
                    // zero reloads.
                    if (r_q == '0) begin
                        w_q_next = c_top;
                        w_wrap   = 1'b1;
                    end else begin
                        w_q_next = r_q ^ w_dn_t;
                    end
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_tc  <= w_wrap;
            // When a wrap and a clear land on the same edge, the wrap wins.
            r_ovf <= w_wrap | (r_ovf & ~clr_ovf);
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8: register width in bits, legal range 2..32.
REQ-002 The block SHALL have a parameter MODULUS, default 0: count modulus for UP/DOWN modes; 0 means 2^WIDTH; otherwise legal range 2..2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: step enable for HOLD/TOGGLE/UP/DOWN operation.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 HOLD, 01 TOGGLE, 10 UP, 11 DOWN.
REQ-007 The block SHALL have port t, input, WIDTH bits: per-bit toggle mask, used in TOGGLE mode only.
REQ-008 The block SHALL have port ld, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port d, input, WIDTH bits: load value.
REQ-010 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of the ovf output.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered state.
REQ-012 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky wrap flag.

Function
REQ-014 Next-state priority SHALL be: rst > ld > (en=0 hold) > mode.
REQ-015 ld=1 SHALL load q<=d at the edge regardless of en and mode; tc<=0; ovf is unaffected except by clr_ovf.
REQ-016 en=0 with ld=0 SHALL hold q and drive tc<=0.
REQ-017 HOLD (en=1) SHALL keep q unchanged and drive tc<=0.
REQ-018 TOGGLE (en=1) SHALL set q<=q^t bitwise, with one T flip-flop per bit; MODULUS is ignored; tc<=0.
REQ-019 UP (en=1) SHALL be implemented as a synchronous T-flip-flop chain, bit i toggling when all lower bits are 1, giving q<=q+1 mod 2^WIDTH when MODULUS=0.
REQ-020 UP with MODULUS!=0: when q>=MODULUS-1, the block SHALL set q<=0 and record a wrap; otherwise q<=q+1.
REQ-021 DOWN (en=1): when q==0, the block SHALL set q<=(MODULUS==0 ? 2^WIDTH-1 : MODULUS-1) and record a wrap; otherwise q<=q-1, including when q>=MODULUS following a load.
REQ-022 A wrap SHALL set tc<=1 for exactly the cycle following the wrapping edge; tc<=0 on every other edge.
REQ-023 A wrap SHALL set ovf<=1; clr_ovf=1 SHALL clear ovf; when a wrap and clr_ovf occur at the same edge, ovf SHALL be 1.
REQ-024 A mode change SHALL take effect at the next edge, with no pipeline; latency from input to q SHALL be one clock.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational input-to-output path.

Reset
REQ-026 Asserting rst SHALL immediately force q=0, tc=0 and ovf=0, independent of clk.
REQ-027 On rst deassertion, the first rising edge SHALL operate normally; rst asserted mid-count SHALL abort the count with no residual tc.

Verification
REQ-028 WIDTH=4, MODULUS=0, UP, en=1 for 16 edges from reset -> q steps 1..15,0; tc=1 only in the cycle q=0 after the wrap; ovf=1 thereafter.
REQ-029 WIDTH=4, MODULUS=10, DOWN from reset -> first edge q=9 with tc=1; after 9 further edges q=0; the next edge gives q=9 and tc=1.
REQ-030 TOGGLE with q=4'b1010 and t=4'b0110 -> q=4'b1100; tc=0; MODULUS=10 has no effect.
REQ-031 MODULUS=10, ld=1 with d=12 while en=0, then UP -> q=12, then q=0 with tc=1; DOWN from d=12 -> q=11.
REQ-032 clr_ovf=1 coincident with an UP wrap (15->0) -> ovf stays 1; clr_ovf alone on the next edge -> ovf=0.
REQ-033 rst pulsed between edges while q=7 and tc=1 -> q=0, tc=0 and ovf=0 immediately, before the next clk edge.
